// File: rtl/exhaustive_vector_checker_if.sv
// Signal bundle between the exhaustive vector checker (slave) and the
// environment that starts it and supplies the DUT / golden responses (master).
interface exhaustive_vector_checker_if #(
  parameter int unsigned IN_W  = 1,
  parameter int unsigned OUT_W = 1,
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] dut_o;
  logic [OUT_W-1:0] gold_o;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [IN_W-1:0]  fail_vec;

  modport master (
    output start, dut_o, gold_o,
    input  stim, busy, done, pass, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    input  start, dut_o, gold_o,
    output stim, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/exhaustive_vector_checker.sv
// Sweeps every IN_W-bit vector, compares DUT against golden after SETTLE cycles.
// Optional macro CHECKER_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module exhaustive_vector_checker #(
  parameter int unsigned IN_W   = 1,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  exhaustive_vector_checker_if.slave   bus
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [IN_W-1:0]  fvec_q, fvec_d;
  logic             pass_q, pass_d;
  logic [OUT_W-1:0] diff;
  logic             mismatch;

  assign diff     = bus.dut_o ^ bus.gold_o;
  assign mismatch = |diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = HOLD;
          stim_d  = '0;
          cnt_d   = CNT_RELOAD;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
          pass_d  = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (!fv_q) begin
              fv_d   = 1'b1;
              fvec_d = stim_q;
            end
          end
`ifdef CHECKER_STOP_ON_FAIL_EN
          if (mismatch) begin
            state_d = DONE;
            pass_d  = 1'b0;
          end else if (stim_q == '1) begin
            state_d = DONE;
            pass_d  = !fv_q;
          end else begin
            stim_d = stim_q + IN_W'(1);
            cnt_d  = CNT_RELOAD;
          end
`else
          // fv_q already records any earlier mismatch of this sweep
          if (stim_q == '1) begin
            state_d = DONE;
            pass_d  = !fv_q && !mismatch;
          end else begin
            stim_d = stim_q + IN_W'(1);
            cnt_d  = CNT_RELOAD;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = (state_q == HOLD);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_vec   = fvec_q;

endmodule
